// File: rtl/rv32i_de_pkg.sv
// Shared types and default widths for the decode-stage operand fetch logic.
package rv32i_de_pkg;

  localparam int DEF_REG_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_INFO_WIDTH = 32;

  function automatic int reg_num(input int addr_width);
    return 1 << addr_width;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    ISS1,
    ISS2,
    DRAIN,
    OUT
  } rd_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for in-flight writebacks, with three combinational lookups.
module reg_scoreboard
  import rv32i_de_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              set_en,
  input  logic [ADDR_WIDTH-1:0]             set_idx,
  input  logic                              clr_en,
  input  logic [ADDR_WIDTH-1:0]             clr_idx,
  input  logic [ADDR_WIDTH-1:0]             lk_a_idx,
  input  logic [ADDR_WIDTH-1:0]             lk_b_idx,
  input  logic [ADDR_WIDTH-1:0]             lk_c_idx,
  output logic                              lk_a_busy,
  output logic                              lk_b_busy,
  output logic                              lk_c_busy,
  output logic [reg_num(ADDR_WIDTH)-1:0]    busy
);

  logic [reg_num(ADDR_WIDTH)-1:0] busy_q, busy_d;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign lk_a_busy = busy_q[lk_a_idx];
  assign lk_b_busy = busy_q[lk_b_idx];
  assign lk_c_busy = busy_q[lk_c_idx];
  assign busy      = busy_q;

endmodule

// File: rtl/reg_read_ctrl.sv
// Operand fetch controller: sequences rs1/rs2 reads over the shared register file
// port, gives writeback priority, and hands operands to execute.
//
// Handshakes: a transfer happens on a cycle where valid & ready are both high;
// valid never depends on ready, and a producer holds payload stable while valid is high.
module reg_read_ctrl
  import rv32i_de_pkg::*;
#(
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INFO_WIDTH = DEF_INFO_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dec_valid,
  output logic                           dec_ready,
  input  logic [ADDR_WIDTH-1:0]          dec_rs1,
  input  logic [ADDR_WIDTH-1:0]          dec_rs2,
  input  logic [ADDR_WIDTH-1:0]          dec_rd,
  input  logic                           dec_rs1_used,
  input  logic                           dec_rs2_used,
  input  logic                           dec_rd_used,
  input  logic [INFO_WIDTH-1:0]          dec_info,
  input  logic                           wb_valid,
  output logic                           wb_ready,
  input  logic [ADDR_WIDTH-1:0]          wb_rd,
  input  logic [REG_WIDTH-1:0]           wb_data,
  output logic                           rf_read_en,
  output logic                           rf_write_en,
  output logic [ADDR_WIDTH-1:0]          rf_addr,
  output logic [REG_WIDTH-1:0]           rf_wr_data,
  input  logic                           rf_rd_data_val,
  input  logic [REG_WIDTH-1:0]           rf_rd_data,
  output logic                           ex_valid,
  input  logic                           ex_ready,
  output logic [REG_WIDTH-1:0]           ex_op1,
  output logic [REG_WIDTH-1:0]           ex_op2,
  output logic [INFO_WIDTH-1:0]          ex_info,
  output rd_state_e                      dbg_state,
  output logic [reg_num(ADDR_WIDTH)-1:0] dbg_busy
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
  logic                  need1_q, need2_q;
  logic [REG_WIDTH-1:0]  op1_q, op2_q, wr_data_q;
  logic [INFO_WIDTH-1:0] info_q;
  logic                  rd_pend_q, rd_tgt_q, issue_tgt;
  logic                  accept, wb_acc, stall, drained;
  logic                  busy_rs1, busy_rs2, busy_rd;

  assign wb_ready = ~rst;
  assign wb_acc   = wb_valid & ~rst;
  assign accept   = dec_valid & dec_ready;
  assign stall    = (dec_rs1_used & busy_rs1) | (dec_rs2_used & busy_rs2) | (dec_rd_used & busy_rd);
  // A read returning this cycle counts as drained so DRAIN costs only one cycle.
  assign drained  = ~rd_pend_q | rf_rd_data_val;

  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept & dec_rd_used & (dec_rd != '0)),
    .set_idx  (dec_rd),
    .clr_en   (wb_acc),
    .clr_idx  (wb_rd),
    .lk_a_idx (dec_rs1),
    .lk_b_idx (dec_rs2),
    .lk_c_idx (dec_rd),
    .lk_a_busy(busy_rs1),
    .lk_b_busy(busy_rs2),
    .lk_c_busy(busy_rd),
    .busy     (dbg_busy)
  );

  always_comb begin
    state_d     = state_q;
    dec_ready   = 1'b0;
    ex_valid    = 1'b0;
    rf_read_en  = 1'b0;
    rf_write_en = 1'b0;
    rf_addr     = '0;
    issue_tgt   = 1'b0;
    if (!rst) begin
      rf_write_en = wb_valid & (wb_rd != '0);
      unique case (state_q)
        IDLE: begin
          dec_ready = ~stall;
          if (dec_valid & ~stall) state_d = ISS1;
        end
        // Unneeded reads fall through to the next phase in the same cycle.
        ISS1: begin
          if (need1_q) begin
            if (!wb_valid) begin
              rf_read_en = 1'b1;
              state_d    = need2_q ? ISS2 : DRAIN;
            end
          end else if (need2_q) begin
            if (!wb_valid) begin
              rf_read_en = 1'b1;
              issue_tgt  = 1'b1;
              state_d    = DRAIN;
            end else begin
              state_d = ISS2;
            end
          end else begin
            state_d = OUT;
          end
        end
        ISS2: begin
          if (!wb_valid) begin
            rf_read_en = 1'b1;
            issue_tgt  = 1'b1;
            state_d    = DRAIN;
          end
        end
        DRAIN: begin
          if (drained) state_d = OUT;
        end
        OUT: begin
          ex_valid = 1'b1;
          if (ex_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (wb_valid)        rf_addr = wb_rd;
      else if (rf_read_en) rf_addr = issue_tgt ? rs2_q : rs1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      need1_q   <= 1'b0;
      need2_q   <= 1'b0;
      info_q    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      wr_data_q <= '0;
      rd_pend_q <= 1'b0;
      rd_tgt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wb_valid) wr_data_q <= wb_data;
      if (rf_read_en) begin
        rd_pend_q <= 1'b1;
        rd_tgt_q  <= issue_tgt;
      end else if (rf_rd_data_val) begin
        rd_pend_q <= 1'b0;
      end
      // Returns with no read in flight (e.g. issued before a reset) are dropped.
      if (rd_pend_q && rf_rd_data_val) begin
        if (rd_tgt_q) op2_q <= rf_rd_data;
        else          op1_q <= rf_rd_data;
      end
      if (accept) begin
        rs1_q   <= dec_rs1;
        rs2_q   <= dec_rs2;
        need1_q <= dec_rs1_used & (dec_rs1 != '0);
        need2_q <= dec_rs2_used & (dec_rs2 != '0);
        info_q  <= dec_info;
        op1_q   <= '0;
        op2_q   <= '0;
      end
    end
  end

  assign rf_wr_data = wr_data_q;
  assign ex_op1     = op1_q;
  assign ex_op2     = op2_q;
  assign ex_info    = info_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_reg_read_ctrl.sv
// Directed timing checks plus a randomized run against a transaction-level model
// of register values and in-flight destinations.
module tb_reg_read_ctrl;
  import rv32i_de_pkg::*;

  localparam int EXP_W = 101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0, dec_ready;
  logic [3:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic        dec_rs1_used = 1'b0, dec_rs2_used = 1'b0, dec_rd_used = 1'b0;
  logic [31:0] dec_info = '0;
  logic        wb_valid = 1'b0, wb_ready;
  logic [3:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        rf_read_en, rf_write_en;
  logic [3:0]  rf_addr;
  logic [31:0] rf_wr_data;
  logic        rf_rd_data_val;
  logic [31:0] rf_rd_data;
  logic        ex_valid, ex_ready = 1'b0;
  logic [31:0] ex_op1, ex_op2, ex_info;
  rd_state_e   dbg_state;
  logic [15:0] dbg_busy;

  // register file model: one-cycle read, write data taken the cycle after the strobe
  logic [31:0] mem [16];
  logic        rf_val_m = 1'b0, wr_pend = 1'b0, stray_val = 1'b0;
  logic [31:0] rf_data_m = '0;
  logic [3:0]  wr_addr = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]      arch [16];
  logic             sb   [16];
  logic [3:0]       cand [$];
  logic [EXP_W-1:0] exp_q[$];
  logic             cur_valid = 1'b0;
  logic [3:0]       cur_rs1, cur_rs2, cur_rd;
  logic             cur_u1, cur_u2, cur_ud;
  logic [31:0]      cur_info;

  reg_read_ctrl #(.REG_WIDTH(32), .ADDR_WIDTH(4), .INFO_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd_used(dec_rd_used),
    .dec_info(dec_info),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_read_en(rf_read_en), .rf_write_en(rf_write_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .rf_rd_data_val(rf_rd_data_val), .rf_rd_data(rf_rd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_info(ex_info), .dbg_state(dbg_state), .dbg_busy(dbg_busy)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    rf_val_m <= rf_read_en;
    if (rf_read_en) rf_data_m <= mem[rf_addr];
    wr_pend <= rf_write_en;
    wr_addr <= rf_addr;
    if (wr_pend) mem[wr_addr] <= rf_wr_data;
  end

  assign rf_rd_data_val = rf_val_m | stray_val;
  assign rf_rd_data     = stray_val ? 32'hDEAD_BEEF : rf_data_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_in();
    dec_valid = 1'b0; wb_valid = 1'b0; ex_ready = 1'b0; stray_val = 1'b0;
  endtask

  task automatic drive_dec(input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                           input logic u2, input logic [3:0] rd, input logic ud,
                           input logic [31:0] info);
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
    dec_rd = rd; dec_rd_used = ud; dec_info = info;
  endtask

  task automatic wb_write(input logic [3:0] idx, input logic [31:0] d);
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = idx; wb_data = d;
    if (idx != 0) arch[idx] = d;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic wait_ex(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (ex_valid) return;
      @(negedge clk); #1;
    end
    check({tag, "_timeout"}, 64'(ex_valid), 64'(1));
  endtask

  task automatic consume();
    @(negedge clk); ex_ready = 1'b1; #1;
    @(negedge clk); ex_ready = 1'b0;
  endtask

  task automatic rnd_cycle(input bit gen_new);
    logic hazard;
    logic [EXP_W-1:0] e;
    int k;
    @(negedge clk);
    if (gen_new && !cur_valid && $urandom_range(0, 3) != 0) begin
      cur_valid = 1'b1;
      cur_rs1 = 4'($urandom_range(0, 7)); cur_u1 = 1'($urandom_range(0, 1));
      cur_rs2 = 4'($urandom_range(0, 7)); cur_u2 = 1'($urandom_range(0, 1));
      cur_rd  = 4'($urandom_range(0, 7)); cur_ud = 1'($urandom_range(0, 1));
      cur_info = $urandom;
    end
    if (cur_valid) drive_dec(cur_rs1, cur_u1, cur_rs2, cur_u2, cur_rd, cur_ud, cur_info);
    else dec_valid = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = $urandom; k = -1;
    if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
      k = int'($urandom_range(0, cand.size() - 1));
      wb_valid = 1'b1; wb_rd = cand[k];
    end else if ($urandom_range(0, 15) == 0) begin
      wb_valid = 1'b1;
    end
    ex_ready = gen_new ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    hazard = (cur_u1 && sb[cur_rs1]) || (cur_u2 && sb[cur_rs2]) || (cur_ud && sb[cur_rd]);
    if (dec_valid && hazard) check("rnd_stall", 64'(dec_ready), 64'(0));
    check("rnd_wen", 64'(rf_write_en), 64'(wb_valid && wb_rd != 0));
    if (ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        check("rnd_ex_unexpected", 64'(ex_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("rnd_op1", 64'(ex_op1), 64'(e[31:0]));
        check("rnd_op2", 64'(ex_op2), 64'(e[63:32]));
        check("rnd_info", 64'(ex_info), 64'(e[95:64]));
        if (e[100]) cand.push_back(e[99:96]);
      end
    end
    if (wb_valid) begin
      if (wb_rd != 0) arch[wb_rd] = wb_data;
      sb[wb_rd] = 1'b0;
      if (k >= 0) cand.delete(k);
    end
    if (dec_valid && dec_ready) begin
      e = {cur_ud && cur_rd != 0, cur_rd, cur_info,
           (cur_u2 && cur_rs2 != 0) ? arch[cur_rs2] : 32'h0,
           (cur_u1 && cur_rs1 != 0) ? arch[cur_rs1] : 32'h0};
      exp_q.push_back(e);
      if (cur_ud && cur_rd != 0) sb[cur_rd] = 1'b1;
      cur_valid = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin arch[i] = '0; sb[i] = 1'b0; end
    // reset: requests offered during reset must be ignored
    rst = 1'b1;
    @(negedge clk);
    drive_dec(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 32'h5);
    wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 32'h99;
    #1;
    check("rst_dec_ready", 64'(dec_ready), 64'(0));
    check("rst_wb_ready", 64'(wb_ready), 64'(0));
    check("rst_wen", 64'(rf_write_en), 64'(0));
    @(negedge clk); idle_in(); rst = 1'b0; #1;
    check("post_rst_state", 64'(dbg_state), 64'(IDLE));
    check("post_rst_busy", 64'(dbg_busy), 64'(0));
    check("post_rst_ex_valid", 64'(ex_valid), 64'(0));
    check("post_rst_ops", {ex_op1, ex_op2}, 64'(0));
    check("post_rst_wr_data", 64'(rf_wr_data), 64'(0));
    check("post_rst_wb_ready", 64'(wb_ready), 64'(1));

    // two-source instruction, no contention
    wb_write(4'd3, 32'h11);
    wb_write(4'd5, 32'h22);
    @(negedge clk); drive_dec(4'd3, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 32'hA1); #1;
    check("t1_accept", 64'(dec_ready), 64'(1));
    @(negedge clk); dec_valid = 1'b0; #1;
    check("t1_iss1", {rf_read_en, rf_addr}, {1'b1, 4'd3});
    @(negedge clk); #1;
    check("t1_iss2", {rf_read_en, rf_addr}, {1'b1, 4'd5});
    @(negedge clk); #1;
    check("t1_t3_ex_valid", 64'(ex_valid), 64'(0));
    @(negedge clk); #1;
    check("t1_t4_ex_valid", 64'(ex_valid), 64'(1));
    check("t1_ops", {ex_op1, ex_op2}, {32'h11, 32'h22});
    check("t1_info", 64'(ex_info), 64'hA1);
    consume();

    // zero-source instruction
    drive_dec(4'd0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 32'hB2); #1;
    check("t2_accept", 64'(dec_ready), 64'(1));
    @(negedge clk); dec_valid = 1'b0; #1;
    check("t2_no_read", {rf_read_en, ex_valid}, 64'(0));
    @(negedge clk); #1;
    check("t2_t2_ex_valid", 64'(ex_valid), 64'(1));
    check("t2_ops", {ex_op1, ex_op2}, 64'(0));
    consume();

    // RAW hazard against an in-flight destination
    drive_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 32'hC3); #1;
    check("t3_accept_a", 64'(dec_ready), 64'(1));
    @(negedge clk); dec_valid = 1'b0; ex_ready = 1'b1; #1;
    wait_ex("t3_a");
    @(negedge clk); ex_ready = 1'b0;
    drive_dec(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 32'hC4); #1;
    check("t3_busy7", 64'(dbg_busy[7]), 64'(1));
    check("t3_stall0", 64'(dec_ready), 64'(0));
    @(negedge clk); #1;
    check("t3_stall1", 64'(dec_ready), 64'(0));
    @(negedge clk); wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 32'hABCD; arch[7] = 32'hABCD; #1;
    check("t3_stall_at_wb", 64'(dec_ready), 64'(0));
    @(negedge clk); wb_valid = 1'b0; #1;
    check("t3_accept_b", 64'(dec_ready), 64'(1));
    check("t3_wr_hold", 64'(rf_wr_data), 64'hABCD);
    @(negedge clk); dec_valid = 1'b0; #1;
    wait_ex("t3_b");
    check("t3_op1", 64'(ex_op1), 64'hABCD);
    consume();

    // writeback holds the port during ISS1 (wb_rd = 0: port used, no write)
    drive_dec(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 32'hD5); #1;
    check("t4_accept", 64'(dec_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); dec_valid = 1'b0; wb_valid = 1'b1; wb_rd = 4'd0; wb_data = 32'h77; #1;
      check("t4_blocked", {rf_read_en, rf_write_en}, 64'(0));
    end
    @(negedge clk); wb_valid = 1'b0; #1;
    check("t4_issue", {rf_read_en, rf_addr}, {1'b1, 4'd3});
    wait_ex("t4");
    check("t4_ops", {ex_op1, ex_op2}, {32'h11, 32'h0});

    // execute back-pressure in OUT
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive_dec(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 32'hE6); #1;
      check("t5_hold_valid", {ex_valid, dec_ready}, {1'b1, 1'b0});
      check("t5_hold_data", {ex_op1, ex_info}, {32'h11, 32'hD5});
    end
    @(negedge clk); dec_valid = 1'b0; ex_ready = 1'b1; #1;
    @(negedge clk); ex_ready = 1'b0;

    // reset while in ISS2, followed by a stray read return
    drive_dec(4'd3, 1'b1, 4'd5, 1'b1, 4'd9, 1'b1, 32'hF7); #1;
    check("t6_accept", 64'(dec_ready), 64'(1));
    @(negedge clk); dec_valid = 1'b0; #1;
    check("t6_busy9", 64'(dbg_busy[9]), 64'(1));
    @(negedge clk); rst = 1'b1; #1;
    check("t6_in_iss2", 64'(dbg_state), 64'(ISS2));
    check("t6_rst_outputs", {rf_read_en, wb_ready, ex_valid}, 64'(0));
    @(negedge clk); rst = 1'b0; stray_val = 1'b1; #1;
    check("t6_state", 64'(dbg_state), 64'(IDLE));
    check("t6_busy", 64'(dbg_busy), 64'(0));
    check("t6_ex_valid", 64'(ex_valid), 64'(0));
    @(negedge clk); stray_val = 1'b0; #1;
    check("t6_ops", {ex_op1, ex_op2}, 64'(0));

    // randomized traffic
    idle_in();
    for (int i = 0; i < 2500; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || cur_valid); i++) rnd_cycle(1'b0);
    check("rnd_drained", 64'(exp_q.size()) + 64'(cur_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
